add_bcd_display: RTL and testbench
==================================

Name: add_bcd_display

Overview:
- Parametrised successor of the team's 4-bit switch adder with 7-segment decimal display.
- Adds or subtracts two W-bit unsigned operands on a start request.
- Converts the magnitude to BCD with a sequential double-dabble engine, one bit per clock.
- Drives N_DIG active-low 7-segment digits plus a sign digit, with optional leading-zero blanking; output is held until the next result.

Parameters:
- W, 4, operand width in bits (≥2)
- N_DIG, 2, number of decimal digits driven; must satisfy 10^N_DIG > 2^(W+1)-2; elaboration error otherwise
- LZ_BLANK, 1, 1 = blank leading zero digits (digit 0 is never blanked); 0 = show all zeros

Ports:
- CLOCK_50  in  1  single system clock, all logic on rising edge
- RST_N  in  1  synchronous, active-low reset
- A  in  W  operand A (unsigned)
- B  in  W  operand B (unsigned)
- SUB  in  1  0 = A+B, 1 = A−B
- START  in  1  request; sampled only in IDLE
- BUSY  out  1  high while a conversion is in progress
- DONE  out  1  one-cycle pulse when displays update
- HEX_OUT  out  7*N_DIG  digit i at [7*i+6 : 7*i]; within a slice bit 6 = seg a … bit 0 = seg g; active-low
- HEX_SIGN  out  7  sign digit, same encoding

Behaviour:
- Reset (RST_N=0 at a clock edge):
  - state=IDLE, BUSY=0, DONE=0, HEX_SIGN=1111111.
  - Digit 0 = 0000001 ("0"); other digits = 1111111 if LZ_BLANK, else 0000001.
  - Reset mid-conversion aborts the operation and discards partial results.
- Segment codes, bits a..g, active-low:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100.
  - blank=1111111, minus=1111110 (seg g only).
- IDLE:
  - On START=1, capture A, B and SUB.
  - Compute result as a W+1-bit value: add → A+B; sub → |A−B|, neg = (B>A).
  - Load the result into a binary shift register, clear the 4*N_DIG-bit BCD register, cnt=0, go to CONV.
  - BUSY=1 from the next cycle.
- CONV, one iteration per cycle:
  - Every BCD nibble ≥5 gets +3.
  - Then {bcd,bin} is shifted left by 1.
  - cnt++. After W+1 iterations go to DISP.
- DISP, one cycle:
  - Encode each nibble to HEX_OUT.
  - Blanking: nibble i is blanked when LZ_BLANK=1, i>0 and all nibbles ≥i are 0.
  - HEX_SIGN = minus if neg, else blank. neg is never set when the result is 0.
  - DONE=1 for exactly this cycle. BUSY drops with the return to IDLE.
- Latency: START sampled at edge k → HEX outputs and DONE update at edge k+W+2.
- START while BUSY is ignored; nothing is queued.
- START held high re-triggers on the first IDLE cycle after DISP.
- A, B and SUB changes during BUSY do not affect the current result.
- HEX outputs change only at reset and in DISP; they are glitch-free registered outputs.
- The result never overflows because the W+1-bit sum is covered by the N_DIG constraint.

Decomposition:
- Shared package seg7_pkg holds:
  - SEG_DIGIT[0:9], SEG_BLANK and SEG_MINUS constants.
  - State enum {IDLE, CONV, DISP}.
- One sub-module, bcd_to_seg7: combinational nibble → 7-bit pattern, with a blank input; non-BCD nibbles map to SEG_BLANK.
- Instantiate bcd_to_seg7 N_DIG times via generate.

Test Plan:
- Reset: hold RST_N=0 two cycles → HEX_OUT[6:0]=0000001, HEX_OUT[13:7]=1111111, HEX_SIGN=1111111, BUSY=0, DONE=0.
- W=4, A=9, B=6, SUB=0, START pulse at edge k → DONE at k+6; digit1=1001111 ("1"), digit0=0100100 ("5"), sign blank.
- W=4, A=15, B=15 add → "30": digit1=0000110, digit0=0000001. Then A=3, B=7, SUB=1 → digit0=1001100 ("4"), digit1 blank, HEX_SIGN=1111110.
- During BUSY, toggle START and change A/B → result unchanged, exactly one DONE pulse. Separately, RST_N=0 at cycle 3 of CONV → reset values, no DONE.
- W=8, N_DIG=3: 255+255 → "510"; 0+0 → "0" with digits 1–2 blank. With LZ_BLANK=0, 0+0 → "000".

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants and types for the BCD adder display.
// Segment order a..g in bits 6..0, active-low.
package seg7_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DISP
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b1111110;

  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b0000001,
    7'b1001111,
    7'b0010010,
    7'b0000110,
    7'b1001100,
    7'b0100100,
    7'b0100000,
    7'b0001111,
    7'b0000000,
    7'b0000100
  };

  function automatic longint unsigned pow10(input int n);
    longint unsigned p;
    p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Nibble to active-low 7-segment pattern.
// Non-BCD codes and the blank request show nothing.
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] i_nib,
  input  logic       i_blank,
  output logic [6:0] o_seg
);

  // pure lookup, blank overrides the digit
  always_comb begin
    o_seg = SEG_BLANK;
    if (!i_blank) begin
      unique case (i_nib)
        4'd0:    o_seg = SEG_DIGIT[0];
        4'd1:    o_seg = SEG_DIGIT[1];
        4'd2:    o_seg = SEG_DIGIT[2];
        4'd3:    o_seg = SEG_DIGIT[3];
        4'd4:    o_seg = SEG_DIGIT[4];
        4'd5:    o_seg = SEG_DIGIT[5];
        4'd6:    o_seg = SEG_DIGIT[6];
        4'd7:    o_seg = SEG_DIGIT[7];
        4'd8:    o_seg = SEG_DIGIT[8];
        4'd9:    o_seg = SEG_DIGIT[9];
        default: o_seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/add_bcd_display.sv
// Add/subtract two operands, convert with a serial
// double-dabble and drive registered 7-segment digits.
module add_bcd_display
  import seg7_pkg::*;
#(
  parameter int W        = 4,
  parameter int N_DIG    = 2,
  parameter int LZ_BLANK = 1
) (
  input  logic               CLOCK_50,
  input  logic               RST_N,
  input  logic [W-1:0]       A,
  input  logic [W-1:0]       B,
  input  logic               SUB,
  input  logic               START,
  output logic               BUSY,
  output logic               DONE,
  output logic [7*N_DIG-1:0] HEX_OUT,
  output logic [6:0]         HEX_SIGN
);

  localparam int BW = 4 * N_DIG;
  localparam int CW = $clog2(W + 2);
  localparam longint unsigned MAXV =
    (64'd1 << (W + 1)) - 64'd2;

  if (W < 2) begin : g_bad_w
    $error("add_bcd_display: W must be >= 2");
  end

  if (pow10(N_DIG) <= MAXV) begin : g_bad_dig
    $error("add_bcd_display: N_DIG too small for W");
  end

  state_t             r_state;
  logic [W:0]         r_bin;
  logic [BW-1:0]      r_bcd;
  logic [CW-1:0]      r_cnt;
  logic               r_neg;
  logic               r_busy;
  logic               r_done;
  logic [7*N_DIG-1:0] r_hex;
  logic [6:0]         r_sign;

  logic [W:0]         w_res;
  logic               w_neg;
  logic [BW-1:0]      w_adj;
  logic [N_DIG-1:0]   w_blank;
  logic [7*N_DIG-1:0] w_seg;

  // magnitude and sign of the requested operation
  always_comb begin
    w_neg = SUB && (B > A);
    if (!SUB)
      w_res = (W+1)'(A) + (W+1)'(B);
    else if (w_neg)
      w_res = (W+1)'(B) - (W+1)'(A);
    else
      w_res = (W+1)'(A) - (W+1)'(B);
  end

  // add 3 to every nibble of 5 or more
  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < N_DIG; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5)
        w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    end
  end

  // blank a digit when it and all above are zero
  always_comb begin
    logic v_zero;
    v_zero  = 1'b1;
    w_blank = '0;
    for (int i = N_DIG - 1; i > 0; i--) begin
      v_zero = v_zero && (r_bcd[4*i +: 4] == 4'd0);
      w_blank[i] = (LZ_BLANK != 0) && v_zero;
    end
  end

  for (genvar g = 0; g < N_DIG; g++) begin : g_dig
    bcd_to_seg7 u_seg (
      .i_nib   (r_bcd[4*g +: 4]),
      .i_blank (w_blank[g]),
      .o_seg   (w_seg[7*g +: 7])
    );
  end

  // control FSM with registered outputs
  always_ff @(posedge CLOCK_50) begin
    if (!RST_N) begin
      r_state <= IDLE;
      r_bin   <= '0;
      r_bcd   <= '0;
      r_cnt   <= '0;
      r_neg   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sign  <= SEG_BLANK;
      for (int i = 0; i < N_DIG; i++) begin
        if (i == 0 || LZ_BLANK == 0)
          r_hex[7*i +: 7] <= SEG_DIGIT[0];
        else
          r_hex[7*i +: 7] <= SEG_BLANK;
      end
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (START) begin
            r_bin   <= w_res;
            r_neg   <= w_neg;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= CONV;
          end
        end
        CONV: begin
          r_bcd <= {w_adj[BW-2:0], r_bin[W]};
          r_bin <= {r_bin[W-1:0], 1'b0};
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == CW'(W))
            r_state <= DISP;
        end
        DISP: begin
          r_hex   <= w_seg;
          r_sign  <= r_neg ? SEG_MINUS : SEG_BLANK;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign BUSY     = r_busy;
  assign DONE     = r_done;
  assign HEX_OUT  = r_hex;
  assign HEX_SIGN = r_sign;

endmodule

// File: tb/tb_add_bcd_display.sv
// Randomised bench for add_bcd_display against a
// decimal reference model, three configurations.
module tb_add_bcd_display;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] a;
  logic [7:0] b;
  logic       sub;
  logic [2:0] start;
  logic [2:0] busy;
  logic [2:0] done;
  logic [13:0] hex0;
  logic [20:0] hex1;
  logic [20:0] hex2;
  logic [6:0] sign0;
  logic [6:0] sign1;
  logic [6:0] sign2;

  int n_vec = 0;
  int n_err = 0;

  logic [6:0] tab [10] = '{
    7'b0000001, 7'b1001111, 7'b0010010,
    7'b0000110, 7'b1001100, 7'b0100100,
    7'b0100000, 7'b0001111, 7'b0000000,
    7'b0000100
  };

  always #5 clk = ~clk;

  add_bcd_display #(
    .W(4), .N_DIG(2), .LZ_BLANK(1)
  ) u_d0 (
    .CLOCK_50 (clk),
    .RST_N    (rst_n),
    .A        (a[3:0]),
    .B        (b[3:0]),
    .SUB      (sub),
    .START    (start[0]),
    .BUSY     (busy[0]),
    .DONE     (done[0]),
    .HEX_OUT  (hex0),
    .HEX_SIGN (sign0)
  );

  add_bcd_display #(
    .W(8), .N_DIG(3), .LZ_BLANK(1)
  ) u_d1 (
    .CLOCK_50 (clk),
    .RST_N    (rst_n),
    .A        (a),
    .B        (b),
    .SUB      (sub),
    .START    (start[1]),
    .BUSY     (busy[1]),
    .DONE     (done[1]),
    .HEX_OUT  (hex1),
    .HEX_SIGN (sign1)
  );

  add_bcd_display #(
    .W(8), .N_DIG(3), .LZ_BLANK(0)
  ) u_d2 (
    .CLOCK_50 (clk),
    .RST_N    (rst_n),
    .A        (a),
    .B        (b),
    .SUB      (sub),
    .START    (start[2]),
    .BUSY     (busy[2]),
    .DONE     (done[2]),
    .HEX_OUT  (hex2),
    .HEX_SIGN (sign2)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  function automatic logic [20:0] hex_of(input int d);
    if (d == 0) return {7'h7F, hex0};
    if (d == 1) return hex1;
    return hex2;
  endfunction

  function automatic logic [6:0] sign_of(input int d);
    if (d == 0) return sign0;
    if (d == 1) return sign1;
    return sign2;
  endfunction

  function automatic int wd(input int d);
    return (d == 0) ? 4 : 8;
  endfunction

  function automatic int nd(input int d);
    return (d == 0) ? 2 : 3;
  endfunction

  function automatic bit lzb(input int d);
    return d != 2;
  endfunction

  // decimal digits of v, unused positions blank
  function automatic logic [20:0] exp_hex(
      input int v, input int ndig, input bit lz);
    logic [20:0] r;
    int p;
    p = 1;
    for (int i = 0; i < 3; i++) begin
      if (i >= ndig)
        r[7*i +: 7] = 7'b1111111;
      else if (lz && i > 0 && v < p)
        r[7*i +: 7] = 7'b1111111;
      else
        r[7*i +: 7] = tab[(v / p) % 10];
      p = p * 10;
    end
    return r;
  endfunction

  task automatic run(input int d, input int av,
                     input int bv, input bit sv);
    int w;
    int v;
    int j;
    bit ng;
    logic [20:0] eh;
    logic [6:0] es;
    w  = wd(d);
    av = av % (1 << w);
    bv = bv % (1 << w);
    if (sv) v = (av > bv) ? av - bv : bv - av;
    else    v = av + bv;
    ng = sv && (bv > av);
    eh = exp_hex(v, nd(d), lzb(d));
    es = ng ? 7'b1111110 : 7'b1111111;
    @(negedge clk);
    a = 8'(av);
    b = 8'(bv);
    sub = sv;
    start[d] = 1'b1;
    @(negedge clk);
    start[d] = 1'b0;
    chk($sformatf("busy%0d", d), 32'(busy[d]), 1);
    j = 0;
    while (!done[d] && j < 40) begin
      @(negedge clk);
      j++;
    end
    chk($sformatf("lat%0d", d), j, w + 2);
    chk($sformatf("hex%0d %0d%s%0d", d, av,
                  sv ? "-" : "+", bv),
        32'(hex_of(d)), 32'(eh));
    chk($sformatf("sign%0d", d),
        32'(sign_of(d)), 32'(es));
    @(negedge clk);
    chk($sformatf("dpulse%0d", d), 32'(done[d]), 0);
    chk($sformatf("idle%0d", d), 32'(busy[d]), 0);
    chk($sformatf("hold%0d", d),
        32'(hex_of(d)), 32'(eh));
  endtask

  task automatic chk_reset(input string tag);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("%s_hex%0d", tag, d),
          32'(hex_of(d)),
          32'(exp_hex(0, nd(d), lzb(d))));
      chk($sformatf("%s_sign%0d", tag, d),
          32'(sign_of(d)), 32'h7F);
      chk($sformatf("%s_busy%0d", tag, d),
          32'(busy[d]), 0);
      chk($sformatf("%s_done%0d", tag, d),
          32'(done[d]), 0);
    end
  endtask

  initial begin
    int nd_cnt;
    logic [20:0] seen;
    rst_n = 1'b0;
    start = '0;
    a = '0;
    b = '0;
    sub = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset("rst");
    rst_n = 1'b1;

    run(0, 9, 6, 0);
    run(0, 15, 15, 0);
    run(0, 3, 7, 1);
    run(0, 7, 3, 1);
    run(0, 5, 5, 1);
    run(0, 0, 15, 1);
    run(1, 255, 255, 0);
    run(1, 0, 0, 0);
    run(1, 9, 200, 1);
    run(1, 100, 1, 0);
    run(2, 0, 0, 0);
    run(2, 255, 0, 1);
    run(2, 4, 5, 1);

    // operand and START activity while busy
    @(negedge clk);
    a = 8'd9;
    b = 8'd6;
    sub = 1'b0;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    a = 8'd2;
    b = 8'd1;
    sub = 1'b1;
    @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    a = 8'd15;
    nd_cnt = 0;
    seen = '0;
    for (int i = 0; i < 14; i++) begin
      if (done[0]) begin
        nd_cnt++;
        seen = hex_of(0);
      end
      @(negedge clk);
    end
    chk("busy_ndone", nd_cnt, 1);
    chk("busy_hex", 32'(seen),
        32'(exp_hex(15, 2, 1)));
    chk("busy_sign", 32'(sign0), 32'h7F);

    for (int i = 0; i < 15; i++) begin
      run(0, int'($urandom_range(0, 15)),
          int'($urandom_range(0, 15)),
          1'($urandom_range(0, 1)));
      run(1, int'($urandom_range(0, 255)),
          int'($urandom_range(0, 255)),
          1'($urandom_range(0, 1)));
      run(2, int'($urandom_range(0, 255)),
          int'($urandom_range(0, 255)),
          1'($urandom_range(0, 1)));
    end

    // abort a conversion with reset
    run(1, 123, 45, 0);
    @(negedge clk);
    a = 8'd200;
    b = 8'd99;
    sub = 1'b0;
    start[1] = 1'b1;
    @(negedge clk);
    start[1] = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk_reset("abort");
    nd_cnt = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done[1]) nd_cnt++;
    end
    chk("abort_ndone", nd_cnt, 0);
    chk("abort_hex", 32'(hex1),
        32'(exp_hex(0, 3, 1)));

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
